// File: rtl/mac_sched_pkg.sv
// Shared definitions for the MACH/MACL issue controller: op codes, FSM states,
// request payload and op classification helpers.
package mac_sched_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 3;

  localparam logic [OP_W-1:0] MOP_LDS   = 4'h0;
  localparam logic [OP_W-1:0] MOP_MULL  = 4'h1;
  localparam logic [OP_W-1:0] MOP_DMULU = 4'h2;
  localparam logic [OP_W-1:0] MOP_DMULS = 4'h3;
  localparam logic [OP_W-1:0] MOP_MULUW = 4'h6;
  localparam logic [OP_W-1:0] MOP_MULSW = 4'h7;
  localparam logic [OP_W-1:0] MOP_MACL  = 4'h9;
  localparam logic [OP_W-1:0] MOP_MACW  = 4'hB;
  localparam logic [OP_W-1:0] MOP_CLR   = 4'hF;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_OPA,
    MS_BUSY
  } MacSchedState_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [OP_W-1:0]  op;
  } mac_req_t;

  function automatic logic is_mac_op(input logic [OP_W-1:0] op);
    return (op == MOP_MACL) || (op == MOP_MACW);
  endfunction

  // Ops that put a result in flight (MAC only on its second operand phase).
  function automatic logic is_start_op(input logic [OP_W-1:0] op, input logic [SEL_W-1:0] sel);
    return (op == MOP_MULL) || (op == MOP_DMULU) || (op == MOP_DMULS) ||
           (op == MOP_MULUW) || (op == MOP_MULSW) || (is_mac_op(op) && sel[1]);
  endfunction

  // First MAC phase: loads operand A only, never touches MACH/MACL.
  function automatic logic is_mac_first(input logic [OP_W-1:0] op, input logic [SEL_W-1:0] sel);
    return is_mac_op(op) && (sel == 2'b01);
  endfunction

endpackage

// File: rtl/mac_sched_if.sv
// Decode <-> MAC scheduler bus: request/read inputs, forwarded multiplier
// command and stall/status outputs.
//  master: decode side (drives REQ, REQ_SEL, REQ_OP, RD_REQ)
//  slave : mac_sched side (drives MUL_*, STALL, BUSY, DONE, SEQ_ERR)
interface mac_sched_if;
  import mac_sched_pkg::*;

  logic             REQ;
  logic [SEL_W-1:0] REQ_SEL;
  logic [OP_W-1:0]  REQ_OP;
  logic             RD_REQ;
  logic [SEL_W-1:0] MUL_SEL;
  logic [OP_W-1:0]  MUL_OP;
  logic             MUL_WE;
  logic             STALL;
  logic             BUSY;
  logic             DONE;
  logic             SEQ_ERR;

  modport master (
    output REQ, REQ_SEL, REQ_OP, RD_REQ,
    input  MUL_SEL, MUL_OP, MUL_WE, STALL, BUSY, DONE, SEQ_ERR
  );

  modport slave (
    input  REQ, REQ_SEL, REQ_OP, RD_REQ,
    output MUL_SEL, MUL_OP, MUL_WE, STALL, BUSY, DONE, SEQ_ERR
  );
endinterface

// File: rtl/mac_lat_lut.sv
// Op code -> result latency (CE_R ticks). Non-result ops map to 0.
//  op  in  4  MAC op code
//  lat out 3  latency for op
module mac_lat_lut
  import mac_sched_pkg::*;
#(
  parameter int unsigned LAT_W  = 1,
  parameter int unsigned LAT_L  = 2,
  parameter int unsigned LAT_MW = 1,
  parameter int unsigned LAT_ML = 2
) (
  input  logic [OP_W-1:0]  op,
  output logic [CNT_W-1:0] lat
);

  always_comb begin
    lat = '0;
    case (op)
      MOP_MULL, MOP_DMULU, MOP_DMULS: lat = CNT_W'(LAT_L);
      MOP_MULUW, MOP_MULSW:           lat = CNT_W'(LAT_W);
      MOP_MACL:                       lat = CNT_W'(LAT_ML);
      MOP_MACW:                       lat = CNT_W'(LAT_MW);
      default:                        lat = '0;
    endcase
  end

endmodule

// File: rtl/mac_sched.sv
// Issue controller between decode/execute and the MACH/MACL multiplier.
// Forwards ops, sequences MAC operand phases, tracks result latency and
// stalls accesses that would race an in-flight result.
//  CLK, RST_N : clock, async active-low reset
//  CE_R       : clock enable; all state advances only on CE_R
//  RES_N      : synchronous soft reset (active low, sampled on CE_R)
//  bus        : mac_sched_if.slave (request in, multiplier command/status out)
module mac_sched
  import mac_sched_pkg::*;
#(
  parameter int unsigned LAT_W  = 1,
  parameter int unsigned LAT_L  = 2,
  parameter int unsigned LAT_MW = 1,
  parameter int unsigned LAT_ML = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        RES_N,
  mac_sched_if.slave  bus
);

  // Latencies must fit the 3-bit counter and be non-zero.
  if (LAT_W < 1 || LAT_W > 7 || LAT_L < 1 || LAT_L > 7 ||
      LAT_MW < 1 || LAT_MW > 7 || LAT_ML < 1 || LAT_ML > 7) begin : g_lat_chk
    $error("mac_sched: LAT_* parameters must be in 1..7");
  end

  MacSchedState_t   state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n, lat_c;
  logic [OP_W-1:0]  opa_op_r, opa_op_n;
  logic             done_r, done_n;
  logic             seq_err_r, seq_err_n;

  mac_req_t         req_c;
  logic             mac_first_c, start_c, stall_c, accept_c;
  MacSchedState_t   fresh_state_c;
  logic [CNT_W-1:0] fresh_cnt_c;

  assign req_c = '{sel: bus.REQ_SEL, op: bus.REQ_OP};

  mac_lat_lut #(
    .LAT_W (LAT_W),
    .LAT_L (LAT_L),
    .LAT_MW(LAT_MW),
    .LAT_ML(LAT_ML)
  ) u_lut (
    .op (req_c.op),
    .lat(lat_c)
  );

  // Stall while a result is in flight; a MAC-first on the last busy tick may
  // slip through because it only loads operand A.
  always_comb begin
    mac_first_c = is_mac_first(req_c.op, req_c.sel);
    start_c     = is_start_op(req_c.op, req_c.sel);
    stall_c     = 1'b0;
    if (cnt_r != '0) begin
      if (bus.RD_REQ) stall_c = 1'b1;
      if (bus.REQ && !((state_r == MS_BUSY) && (cnt_r == CNT_W'(1)) && mac_first_c))
        stall_c = 1'b1;
    end
    accept_c = bus.REQ && !stall_c && CE_R;
  end

  assign bus.MUL_SEL = req_c.sel;
  assign bus.MUL_OP  = req_c.op;
  assign bus.MUL_WE  = bus.REQ && !stall_c;
  assign bus.STALL   = stall_c;
  assign bus.BUSY    = (cnt_r != '0);
  assign bus.DONE    = done_r;
  assign bus.SEQ_ERR = seq_err_r;

  // Next state/outputs; pulses default low and are only committed on CE_R.
  always_comb begin
    state_n       = state_r;
    cnt_n         = cnt_r;
    opa_op_n      = opa_op_r;
    done_n        = 1'b0;
    seq_err_n     = 1'b0;

    // How an accepted op is handled with no MAC sequence pending.
    fresh_state_c = MS_IDLE;
    fresh_cnt_c   = '0;
    if (mac_first_c) begin
      fresh_state_c = MS_OPA;
    end else if (start_c) begin
      fresh_state_c = MS_BUSY;
      fresh_cnt_c   = lat_c;
    end

    case (state_r)
      MS_IDLE: begin
        if (accept_c) begin
          state_n = fresh_state_c;
          cnt_n   = fresh_cnt_c;
          if (mac_first_c) opa_op_n = req_c.op;
        end
      end
      MS_OPA: begin
        if (accept_c) begin
          if (is_mac_op(req_c.op) && req_c.sel[1] && (req_c.op == opa_op_r)) begin
            state_n = MS_BUSY;
            cnt_n   = lat_c;
          end else begin
            seq_err_n = 1'b1;
            state_n   = fresh_state_c;
            cnt_n     = fresh_cnt_c;
            if (mac_first_c) opa_op_n = req_c.op;
          end
        end
      end
      MS_BUSY: begin
        if (cnt_r == '0) begin
          state_n = MS_IDLE;
        end else begin
          cnt_n = cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            done_n = 1'b1;
            if (accept_c && mac_first_c) begin
              state_n  = MS_OPA;
              opa_op_n = req_c.op;
            end else begin
              state_n = MS_IDLE;
            end
          end
        end
      end
      default: begin
        state_n = MS_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State register; soft reset drops any in-flight count without a DONE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= MS_IDLE;
      cnt_r     <= '0;
      opa_op_r  <= '0;
      done_r    <= 1'b0;
      seq_err_r <= 1'b0;
    end else if (CE_R) begin
      if (!RES_N) begin
        state_r   <= MS_IDLE;
        cnt_r     <= '0;
        opa_op_r  <= '0;
        done_r    <= 1'b0;
        seq_err_r <= 1'b0;
      end else begin
        state_r   <= state_n;
        cnt_r     <= cnt_n;
        opa_op_r  <= opa_op_n;
        done_r    <= done_n;
        seq_err_r <= seq_err_n;
      end
    end
  end

endmodule

// File: tb/tb_mac_sched.sv
module tb_mac_sched;
  import mac_sched_pkg::*;

  localparam int unsigned T_LAT_W  = 1;
  localparam int unsigned T_LAT_L  = 2;
  localparam int unsigned T_LAT_MW = 1;
  localparam int unsigned T_LAT_ML = 2;
  localparam int          N_VEC    = 19;
  localparam int          N_RAND   = 3000;

  logic CLK = 1'b0;
  logic RST_N, CE_R, RES_N;
  always #5 CLK = ~CLK;

  mac_sched_if bus();

  mac_sched #(
    .LAT_W (T_LAT_W),
    .LAT_L (T_LAT_L),
    .LAT_MW(T_LAT_MW),
    .LAT_ML(T_LAT_ML)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .CE_R (CE_R),
    .RES_N(RES_N),
    .bus  (bus)
  );

  typedef struct {
    logic       req;
    logic [1:0] sel;
    logic [3:0] op;
    logic       rd;
    logic       stall;  // before the edge
    logic       we;     // before the edge
    logic       busy;   // after the edge
    logic       done;   // after the edge
    logic       err;    // after the edge
  } vec_t;

  vec_t       vecs [N_VEC];
  logic [3:0] ops  [9];
  int n_chk = 0;
  int n_err = 0;

  // Reference model: pending operand-A op (-1 none) and ticks until result.
  int m_pend, m_rem;
  bit m_done, m_err;

  function automatic vec_t mk(logic req, logic [1:0] sel, logic [3:0] op, logic rd,
                              logic stall, logic we, logic busy, logic done, logic err);
    vec_t v;
    v.req = req; v.sel = sel; v.op = op; v.rd = rd;
    v.stall = stall; v.we = we; v.busy = busy; v.done = done; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic req, input logic [1:0] sel, input logic [3:0] op, input logic rd);
    bus.REQ = req; bus.REQ_SEL = sel; bus.REQ_OP = op; bus.RD_REQ = rd;
  endtask

  // Apply one vector for one clock: combinational checks before, registered after.
  task automatic apply_vec(input vec_t v, input string tag);
    drive(v.req, v.sel, v.op, v.rd);
    #2;
    chk({tag, " stall"}, 8'(bus.STALL), 8'(v.stall));
    chk({tag, " mul_we"}, 8'(bus.MUL_WE), 8'(v.we));
    chk({tag, " mul_op"}, 8'(bus.MUL_OP), 8'(v.op));
    @(posedge CLK); #1;
    chk({tag, " busy"}, 8'(bus.BUSY), 8'(v.busy));
    chk({tag, " done"}, 8'(bus.DONE), 8'(v.done));
    chk({tag, " seq_err"}, 8'(bus.SEQ_ERR), 8'(v.err));
  endtask

  function automatic int lat_of(logic [3:0] op);
    if (op == 4'h1 || op == 4'h2 || op == 4'h3) return int'(T_LAT_L);
    if (op == 4'h6 || op == 4'h7) return int'(T_LAT_W);
    if (op == 4'h9) return int'(T_LAT_ML);
    if (op == 4'hB) return int'(T_LAT_MW);
    return 0;
  endfunction

  function automatic bit m_is_mac(logic [3:0] op);
    return (op == 4'h9) || (op == 4'hB);
  endfunction

  function automatic bit m_is_start(logic [3:0] op, logic [1:0] sel);
    return (op inside {4'h1, 4'h2, 4'h3, 4'h6, 4'h7}) || (m_is_mac(op) && sel[1]);
  endfunction

  function automatic bit m_stall(logic req, logic [1:0] sel, logic [3:0] op, logic rd);
    bit first;
    first = m_is_mac(op) && (sel == 2'b01);
    if (m_rem == 0) return 1'b0;
    return rd || (req && !(m_rem == 1 && first));
  endfunction

  task automatic m_tick(input logic req, input logic [1:0] sel, input logic [3:0] op,
                        input logic rd, input logic ce, input logic res_n);
    bit acc, first, handled;
    if (!ce) return;
    if (!res_n) begin
      m_rem = 0; m_pend = -1; m_done = 0; m_err = 0;
      return;
    end
    first = m_is_mac(op) && (sel == 2'b01);
    acc   = req && !m_stall(req, sel, op, rd);
    m_done = 0; m_err = 0;
    if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) m_done = 1;
      if (acc && first) m_pend = int'(op);
    end else if (acc) begin
      handled = 0;
      if (m_pend >= 0) begin
        if (m_is_mac(op) && sel[1] && int'(op) == m_pend) begin
          m_rem = lat_of(op); handled = 1;
        end else begin
          m_err = 1;
        end
        m_pend = -1;
      end
      if (!handled) begin
        if (first) m_pend = int'(op);
        else if (m_is_start(op, sel)) m_rem = lat_of(op);
      end
    end
  endtask

  initial begin
    logic       r_req, r_rd, r_ce, r_resn, e_stall;
    logic [1:0] r_sel;
    logic [3:0] r_op;

    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h9, 4'hB, 4'hF};

    //            req sel    op   rd  stall we busy done err
    vecs[0]  = mk(1, 2'b11, 4'h7, 0,  0,   1,  1,   0,   0);  // MULS.W issue
    vecs[1]  = mk(0, 2'b00, 4'h0, 1,  1,   0,  0,   1,   0);  // STS stalls, DONE
    vecs[2]  = mk(0, 2'b00, 4'h0, 1,  0,   0,  0,   0,   0);  // STS proceeds
    vecs[3]  = mk(1, 2'b01, 4'h9, 0,  0,   1,  0,   0,   0);  // MAC.L A
    vecs[4]  = mk(1, 2'b10, 4'h9, 0,  0,   1,  1,   0,   0);  // MAC.L B, CNT=2
    vecs[5]  = mk(0, 2'b00, 4'h0, 1,  1,   0,  1,   0,   0);
    vecs[6]  = mk(0, 2'b00, 4'h0, 1,  1,   0,  0,   1,   0);
    vecs[7]  = mk(0, 2'b00, 4'h0, 1,  0,   0,  0,   0,   0);
    vecs[8]  = mk(1, 2'b01, 4'hB, 0,  0,   1,  0,   0,   0);  // MAC.W pair 1
    vecs[9]  = mk(1, 2'b10, 4'hB, 0,  0,   1,  1,   0,   0);
    vecs[10] = mk(1, 2'b01, 4'hB, 0,  0,   1,  0,   1,   0);  // MAC-first at CNT=1
    vecs[11] = mk(1, 2'b10, 4'hB, 0,  0,   1,  1,   0,   0);  // OPA->BUSY no gap
    vecs[12] = mk(1, 2'b10, 4'hB, 0,  1,   0,  0,   1,   0);  // op B stalls at CNT=1
    vecs[13] = mk(1, 2'b10, 4'hB, 0,  0,   1,  1,   0,   0);  // held request goes
    vecs[14] = mk(0, 2'b00, 4'h0, 0,  0,   0,  0,   1,   0);
    vecs[15] = mk(1, 2'b01, 4'h9, 0,  0,   1,  0,   0,   0);  // enter OPA
    vecs[16] = mk(1, 2'b00, 4'h0, 0,  0,   1,  0,   0,   1);  // LDS in OPA
    vecs[17] = mk(1, 2'b10, 4'hB, 0,  0,   1,  1,   0,   0);  // back in IDLE: no err
    vecs[18] = mk(0, 2'b00, 4'h0, 0,  0,   0,  0,   1,   0);

    RST_N = 1'b0; CE_R = 1'b1; RES_N = 1'b1;
    drive(1'b0, 2'b00, 4'h0, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;
    drive(1'b0, 2'b00, 4'h0, 1'b1);
    #2;
    chk("reset stall", 8'(bus.STALL), 8'd0);
    chk("reset busy", 8'(bus.BUSY), 8'd0);
    chk("reset done", 8'(bus.DONE), 8'd0);
    chk("reset seq_err", 8'(bus.SEQ_ERR), 8'd0);
    @(posedge CLK); #1;

    for (int i = 0; i < N_VEC; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Soft reset drops DMULS.L in flight with no DONE.
    apply_vec(mk(1, 2'b11, 4'h3, 0, 0, 1, 1, 0, 0), "res issue");
    RES_N = 1'b0;
    apply_vec(mk(0, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0), "res low");
    RES_N = 1'b1;
    apply_vec(mk(0, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0), "res after");
    apply_vec(mk(1, 2'b11, 4'h6, 0, 0, 1, 1, 0, 0), "res next req");
    apply_vec(mk(0, 2'b00, 4'h0, 0, 0, 0, 0, 1, 0), "res next done");

    // CE_R low freezes the count and holds STALL.
    apply_vec(mk(1, 2'b11, 4'h1, 0, 0, 1, 1, 0, 0), "ce issue");
    CE_R = 1'b0;
    for (int i = 0; i < 5; i++) apply_vec(mk(0, 2'b00, 4'h0, 1, 1, 0, 1, 0, 0), $sformatf("ce frozen%0d", i));
    CE_R = 1'b1;
    apply_vec(mk(0, 2'b00, 4'h0, 1, 1, 0, 1, 0, 0), "ce resume1");
    apply_vec(mk(0, 2'b00, 4'h0, 1, 1, 0, 0, 1, 0), "ce resume2");
    apply_vec(mk(0, 2'b00, 4'h0, 1, 0, 0, 0, 0, 0), "ce resume3");

    // Randomized run against the reference model (DUT is idle here).
    m_pend = -1; m_rem = 0; m_done = 0; m_err = 0;
    for (int i = 0; i < N_RAND; i++) begin
      r_req  = 1'($urandom_range(0, 1));
      r_sel  = 2'($urandom);
      r_op   = ops[$urandom_range(0, 8)];
      r_rd   = ($urandom_range(0, 3) == 0);
      r_ce   = ($urandom_range(0, 9) != 0);
      r_resn = ($urandom_range(0, 49) != 0);
      drive(r_req, r_sel, r_op, r_rd);
      CE_R = r_ce; RES_N = r_resn;
      #2;
      e_stall = m_stall(r_req, r_sel, r_op, r_rd);
      chk($sformatf("rnd%0d stall", i), 8'(bus.STALL), 8'(e_stall));
      chk($sformatf("rnd%0d mul_we", i), 8'(bus.MUL_WE), 8'(r_req && !e_stall));
      chk($sformatf("rnd%0d mul_sel", i), 8'(bus.MUL_SEL), 8'(r_sel));
      m_tick(r_req, r_sel, r_op, r_rd, r_ce, r_resn);
      @(posedge CLK); #1;
      chk($sformatf("rnd%0d busy", i), 8'(bus.BUSY), 8'(m_rem != 0));
      chk($sformatf("rnd%0d done", i), 8'(bus.DONE), 8'(m_done));
      chk($sformatf("rnd%0d seq_err", i), 8'(bus.SEQ_ERR), 8'(m_err));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
